// File: rtl/sseg_scan_decoder_pkg.sv
// Shared scan-bus constants for the lamp/state display: glyphs, anode codes,
// frame FSM encoding and the state-to-lamp map.
package sseg_scan_decoder_pkg;

   localparam logic [6:0] SEG_S     = 7'b0010010;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DIG0  = 7'b1000000;
   localparam logic [6:0] SEG_DIG1  = 7'b1111001;
   localparam logic [6:0] SEG_DIG2  = 7'b0100100;
   localparam logic [6:0] SEG_DIG3  = 7'b0110000;
   localparam logic [6:0] SEG_DIG4  = 7'b0011001;
   localparam logic [6:0] SEG_DIG5  = 7'b0010010;

   localparam logic [3:0] AN_D0   = 4'b1110;
   localparam logic [3:0] AN_D1   = 4'b1101;
   localparam logic [3:0] AN_D2   = 4'b1011;
   localparam logic [3:0] AN_D3   = 4'b0111;
   localparam logic [3:0] AN_IDLE = 4'b1111;
   localparam logic [3:0] AN_XFER = 4'b0000;

   typedef enum logic [1:0] {HUNT, GOT0, GOT1, GOT2} frame_state_t;

   typedef enum logic [2:0] {
      CLS_D0, CLS_D1, CLS_D2, CLS_D3, CLS_IDLE, CLS_XFER, CLS_ILLEGAL
   } anode_cls_t;

   typedef struct packed {
      logic ah;
      logic ph;
      logic g;
   } lamps_t;

   function automatic anode_cls_t anode_class(input logic [3:0] an);
      case (an)
         AN_D0:   return CLS_D0;
         AN_D1:   return CLS_D1;
         AN_D2:   return CLS_D2;
         AN_D3:   return CLS_D3;
         AN_IDLE: return CLS_IDLE;
         AN_XFER: return CLS_XFER;
         default: return CLS_ILLEGAL;
      endcase
   endfunction

   function automatic lamps_t lamp_map(input logic [2:0] state_num);
      lamps_t l;
      case (state_num)
         3'd1:    l = 3'b100;
         3'd2:    l = 3'b110;
         3'd3:    l = 3'b001;
         3'd4:    l = 3'b101;
         3'd5:    l = 3'b111;
         default: l = 3'b000;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Scan bus input and decoded-state outputs of the scan decoder.
interface sseg_scan_decoder_if #(
   parameter int ERR_W = 8
);
   logic [10:0]      sseg_in;
   logic [2:0]       code;
   logic             code_valid;
   logic             code_upd;
   logic             lamp_ah;
   logic             lamp_ph;
   logic             lamp_g;
   logic             digit_err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output sseg_in,
      input  code, code_valid, code_upd, lamp_ah, lamp_ph, lamp_g, digit_err, err_cnt
   );

   modport slave (
      input  sseg_in,
      output code, code_valid, code_upd, lamp_ah, lamp_ph, lamp_g, digit_err, err_cnt
   );
endinterface

// File: rtl/sseg_scan_decoder_char_decode.sv
// Combinational glyph classifier for one active-low segment pattern.
module sseg_char_decode
   import sseg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic       is_s,
   output logic       is_blank,
   output logic       num_valid,
   output logic [2:0] num
);

   always_comb begin
      is_s      = (seg == SEG_S);
      is_blank  = (seg == SEG_BLANK);
      num_valid = 1'b1;
      num       = 3'd0;
      case (seg)
         SEG_DIG0: num = 3'd0;
         SEG_DIG1: num = 3'd1;
         SEG_DIG2: num = 3'd2;
         SEG_DIG3: num = 3'd3;
         SEG_DIG4: num = 3'd4;
         SEG_DIG5: num = 3'd5;
         default:  num_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receives the multiplexed seven-segment scan bus, checks frame order and
// glyphs, debounces complete frames and recovers the state number and lamps.
module sseg_scan_decoder
   import sseg_scan_decoder_pkg::*;
#(
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT       = 16,
   parameter int ERR_W         = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   sseg_scan_decoder_if.slave  bus
);

   localparam logic [3:0] STABLE_M = 4'(STABLE_FRAMES);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] TO_MAX   = 8'(TIMEOUT);

   logic [10:0]      sample;
   frame_state_t     state;
   logic [2:0]       cand;
   logic [3:0]       match;
   logic [7:0]       idle_cnt;
   logic [2:0]       code;
   logic             code_valid;
   logic             code_upd;
   lamps_t           lamps;
   logic             digit_err;
   logic [ERR_W-1:0] err_cnt;

   logic             is_s, is_blank, num_valid;
   logic [2:0]       num;
   anode_cls_t       cls;
   logic             d0_s, expected, complete, proto_err, timeout_hit, publish;
   logic [2:0]       cand_nxt;
   logic [3:0]       match_nxt;

   // Input stage: every decision below works on this registered copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sample <= '0;
      else        sample <= bus.sseg_in;
   end

   sseg_char_decode u_char (
      .seg       (sample[10:4]),
      .is_s      (is_s),
      .is_blank  (is_blank),
      .num_valid (num_valid),
      .num       (num)
   );

   always_comb begin
      cls  = anode_class(sample[3:0]);
      d0_s = (cls == CLS_D0) && is_s;
      case (state)
         GOT0:    expected = (cls == CLS_D1) && is_blank;
         GOT1:    expected = (cls == CLS_D2) && is_blank;
         GOT2:    expected = (cls == CLS_D3) && num_valid;
         default: expected = 1'b0;
      endcase
      complete    = (state == GOT2) && expected;
      proto_err   = (state != HUNT) && !expected && (cls != CLS_IDLE) && (cls != CLS_XFER);
      timeout_hit = (cls == CLS_IDLE) && (idle_cnt == TO_LAST);
      if (num == cand) begin
         cand_nxt  = cand;
         match_nxt = (match >= STABLE_M) ? STABLE_M : match + 4'd1;
      end else begin
         cand_nxt  = num;
         match_nxt = 4'd1;
      end
      publish = (match_nxt == STABLE_M) && (!code_valid || (code != cand_nxt));
   end

   // Frame stage: FSM, debounce, idle timeout and error counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         cand       <= '0;
         match      <= '0;
         idle_cnt   <= '0;
         code       <= '0;
         code_valid <= 1'b0;
         code_upd   <= 1'b0;
         lamps      <= '0;
         digit_err  <= 1'b0;
         err_cnt    <= '0;
      end else begin
         code_upd  <= 1'b0;
         digit_err <= 1'b0;

         if (cls != CLS_IDLE)       idle_cnt <= '0;
         else if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 8'd1;

         if (timeout_hit) begin
            state      <= HUNT;
            match      <= '0;
            code_valid <= 1'b0;
            lamps      <= '0;
            code_upd   <= code_valid;
         end else begin
            if (cls == CLS_XFER) begin
               state <= HUNT;
            end else if (proto_err) begin
               state     <= d0_s ? GOT0 : HUNT;
               digit_err <= 1'b1;
               if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            end else begin
               case (state)
                  HUNT: if (d0_s)     state <= GOT0;
                  GOT0: if (expected) state <= GOT1;
                  GOT1: if (expected) state <= GOT2;
                  GOT2: if (expected) state <= HUNT;
                  default:            state <= HUNT;
               endcase
            end

            if (complete) begin
               cand  <= cand_nxt;
               match <= match_nxt;
               if (publish) begin
                  code       <= cand_nxt;
                  code_valid <= 1'b1;
                  lamps      <= lamp_map(cand_nxt);
                  code_upd   <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.code       = code;
   assign bus.code_valid = code_valid;
   assign bus.code_upd   = code_upd;
   assign bus.lamp_ah    = lamps.ah;
   assign bus.lamp_ph    = lamps.ph;
   assign bus.lamp_g     = lamps.g;
   assign bus.digit_err  = digit_err;
   assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed scan-bus vectors; expected code_upd/digit_err events are queued
// by the stimulus and matched by a monitor whenever the decoder reports one.
module tb_sseg_scan_decoder;

   localparam logic [10:0] F0   = 11'b00100101110;
   localparam logic [10:0] F1   = 11'b11111111101;
   localparam logic [10:0] F2   = 11'b11111111011;
   localparam logic [10:0] IDLE = 11'b11111111111;
   localparam logic [10:0] XFER = 11'b00000000000;
   localparam logic [6:0]  G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
   localparam logic [6:0]  G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
   localparam logic [6:0]  G8 = 7'b0000000;
   localparam logic [1:0]  EV_UPD = 2'b10, EV_ERR = 2'b01;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [31:0] exp_q[$];

   sseg_scan_decoder_if #(.ERR_W(8)) ifc ();

   sseg_scan_decoder #(.STABLE_FRAMES(2), .TIMEOUT(16), .ERR_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Event word: {kind[1:0], code[2:0], valid, ah, ph, g, err_cnt[7:0]}
   task automatic expect_ev(input logic [1:0] kind, input logic [2:0] c, input logic v,
                            input logic [2:0] lamps, input logic [7:0] ec);
      exp_q.push_back({15'd0, kind, c, v, lamps, ec});
   endtask

   task automatic put(input logic [10:0] v);
      ifc.sseg_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [6:0] g);
      put(F0);
      put(F1);
      put(F2);
      put({g, 4'b0111});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_code"},   {29'd0, ifc.code}, 32'd0);
      chk({tag, "_valid"},  {31'd0, ifc.code_valid}, 32'd0);
      chk({tag, "_upd"},    {31'd0, ifc.code_upd}, 32'd0);
      chk({tag, "_lamps"},  {29'd0, ifc.lamp_ah, ifc.lamp_ph, ifc.lamp_g}, 32'd0);
      chk({tag, "_err"},    {31'd0, ifc.digit_err}, 32'd0);
      chk({tag, "_errcnt"}, {24'd0, ifc.err_cnt}, 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      ifc.sseg_in = XFER;
      fork
         begin : stim
            repeat (3) @(posedge clk);
            #1;
            chk_all_zero("reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            // State 3, second frame with an idle gap inside it
            expect_ev(EV_UPD, 3'd3, 1'b1, 3'b001, 8'd0);
            frame(G3);
            put(F0); put(IDLE); put(IDLE); put(F1); put(F2); put({G3, 4'b0111});
            frame(G3);
            put(IDLE);
            chk("s3_code", {29'd0, ifc.code}, 32'd3);
            chk("s3_lamps", {29'd0, ifc.lamp_ah, ifc.lamp_ph, ifc.lamp_g}, 32'b001);
            chk("s3_errcnt", {24'd0, ifc.err_cnt}, 32'd0);

            // State 1, transfer cycle, state 2 with an aborted partial frame
            expect_ev(EV_UPD, 3'd1, 1'b1, 3'b100, 8'd0);
            frame(G1);
            frame(G1);
            put(XFER);
            expect_ev(EV_UPD, 3'd2, 1'b1, 3'b110, 8'd0);
            frame(G2);
            put(F0); put(F1); put(XFER);
            frame(G2);
            put(IDLE);
            chk("s2_code", {29'd0, ifc.code}, 32'd2);
            chk("s2_lamps", {29'd0, ifc.lamp_ah, ifc.lamp_ph, ifc.lamp_g}, 32'b110);

            // Skipped digit, then a stray D2 that must be ignored in HUNT
            expect_ev(EV_ERR, 3'd2, 1'b1, 3'b110, 8'd1);
            put(F0); put(F2); put(IDLE); put(F2); put(IDLE);
            chk("skip_code", {29'd0, ifc.code}, 32'd2);

            // Error on a fresh D0+S restarts at GOT0 and the frame completes
            expect_ev(EV_ERR, 3'd2, 1'b1, 3'b110, 8'd2);
            put(F0); put(F1); put(F0); put(F1); put(F2); put({G5, 4'b0111});
            expect_ev(EV_UPD, 3'd5, 1'b1, 3'b111, 8'd2);
            frame(G5);
            put(IDLE);

            // Non-numeric glyph in D3
            expect_ev(EV_ERR, 3'd5, 1'b1, 3'b111, 8'd3);
            frame(G8);
            put(IDLE);
            chk("g8_code", {29'd0, ifc.code}, 32'd5);

            // Idle timeout boundary: 15 processed idles keep code_valid
            put(XFER);
            repeat (16) put(IDLE);
            chk("to_15_valid", {31'd0, ifc.code_valid}, 32'd1);
            expect_ev(EV_UPD, 3'd5, 1'b0, 3'b000, 8'd3);
            repeat (6) put(IDLE);
            chk("to_valid", {31'd0, ifc.code_valid}, 32'd0);
            chk("to_lamps", {29'd0, ifc.lamp_ah, ifc.lamp_ph, ifc.lamp_g}, 32'd0);
            chk("to_code", {29'd0, ifc.code}, 32'd5);

            expect_ev(EV_UPD, 3'd4, 1'b1, 3'b101, 8'd3);
            frame(G4);
            frame(G4);
            put(IDLE);
            chk("s4_code", {29'd0, ifc.code}, 32'd4);

            // Repeated D0+S while in GOT0: one error per sample, saturating
            put(F0);
            for (int i = 1; i <= 300; i++) begin
               expect_ev(EV_ERR, 3'd4, 1'b1, 3'b101, (3 + i > 255) ? 8'd255 : 8'(3 + i));
               put(F0);
            end
            put(XFER);
            put(IDLE);
            chk("sat_errcnt", {24'd0, ifc.err_cnt}, 32'd255);

            // Asynchronous reset in the middle of a frame
            put(F0);
            put(F1);
            #2;
            rst_n = 1'b0;
            #1;
            chk_all_zero("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            expect_ev(EV_UPD, 3'd0, 1'b1, 3'b000, 8'd0);
            frame(G0);
            frame(G0);
            put(IDLE);
            put(IDLE);
            chk("post_valid", {31'd0, ifc.code_valid}, 32'd1);
            chk("post_code", {29'd0, ifc.code}, 32'd0);

            repeat (3) put(IDLE);
            chk("queue_empty", exp_q.size(), 32'd0);
         end
         begin : monitor
            forever begin
               @(negedge clk);
               if (rst_n && (ifc.code_upd || ifc.digit_err)) begin
                  if (exp_q.size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL unexpected_event: upd=%0b err=%0b code=%0d errcnt=%0d, expected no event",
                              ifc.code_upd, ifc.digit_err, ifc.code, ifc.err_cnt);
                  end else begin
                     chk("event", {15'd0, ifc.code_upd, ifc.digit_err, ifc.code, ifc.code_valid,
                                   ifc.lamp_ah, ifc.lamp_ph, ifc.lamp_g, ifc.err_cnt},
                         exp_q.pop_front());
                  end
               end
            end
         end
         begin : watchdog
            repeat (20000) @(posedge clk);
            $display("FAIL watchdog: cycle budget exhausted, expected stimulus to finish");
            $fatal(1, "watchdog");
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
